// File: rtl/mux_scan_buffer.sv
`default_nettype none
// ============================================================================
// Module      : mux_scan_buffer
// Description : N-channel, W-bit registered multiplexer with a one-entry
//               output holding buffer and a valid/ready output handshake.
//               Channel selection is either manual (sel) or auto-scan, where
//               an internal index steps through the channels after DWELL
//               accepted samples per channel.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   N      number of input channels (2..16)
//   W      data width per channel (1..32)
//   DWELL  accepted samples per channel before auto-scan advances (1..255)
//   SW     select width, $clog2(N) (derived, not overridable)
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   en         in   sample enable
//   mode       in   0 = manual select, 1 = auto-scan
//   sel        in   manual channel select
//   d          in   packed channel data, channel k = d[k*W +: W]
//   out_ready  in   downstream accepts y this cycle
//   oe         in   output enable (only with MUX_SCAN_TRISTATE_EN)
//   out_valid  out  y holds a valid sample
//   y          out  registered sample
//   ch         out  channel index of the sample in y
//   err        out  sticky out-of-range manual select flag
// Build option
//   MUX_SCAN_TRISTATE_EN : adds the oe input; y floats when oe=0.
// ============================================================================
module mux_scan_buffer #(
  parameter int N     = 4,
  parameter int W     = 1,
  parameter int DWELL = 1,
  localparam int SW   = (N > 1) ? $clog2(N) : 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           en,
  input  logic           mode,
  input  logic [SW-1:0]  sel,
  input  logic [N*W-1:0] d,
  input  logic           out_ready,
`ifdef MUX_SCAN_TRISTATE_EN
  input  logic           oe,
`endif
  output logic           out_valid,
  output logic [W-1:0]   y,
  output logic [SW-1:0]  ch,
  output logic           err
);

  typedef enum logic [0:0] {
    ST_MANUAL = 1'b0,
    ST_SCAN   = 1'b1
  } state_t;

  state_t         state_q, state_d;
  logic           out_valid_q, out_valid_d;
  logic [W-1:0]   y_q, y_d;
  logic [SW-1:0]  ch_q, ch_d;
  logic [SW-1:0]  scan_idx_q, scan_idx_d;
  logic [7:0]     dwell_cnt_q, dwell_cnt_d;
  logic           err_q, err_d;

  logic           enter_scan;
  logic           load;
  logic           sel_oob;
  logic [SW-1:0]  chan;
  logic [W-1:0]   chan_data;

  // When N fills the select space every sel value is a real channel.
  generate
    if (N == (1 << SW)) begin : g_oob_none
      assign sel_oob = 1'b0;
    end else begin : g_oob_cmp
      assign sel_oob = (sel >= SW'(N));
    end
  endgenerate

  // The cycle in which mode first reads 1 only re-arms the scan position.
  assign enter_scan = mode & (state_q == ST_MANUAL);
  assign load       = en & (~out_valid_q | out_ready) & ~enter_scan;
  assign chan       = mode ? scan_idx_q : sel;

  // Out-of-range channels match no arm and therefore read as zero.
  always_comb begin
    chan_data = '0;
    for (int k = 0; k < N; k++) begin
      if (chan == SW'(k)) begin
        chan_data = d[k*W +: W];
      end
    end
  end

  always_comb begin
    state_d     = mode ? ST_SCAN : ST_MANUAL;
    out_valid_d = out_valid_q;
    y_d         = y_q;
    ch_d        = ch_q;
    scan_idx_d  = scan_idx_q;
    dwell_cnt_d = dwell_cnt_q;
    err_d       = err_q;

    if (enter_scan) begin
      scan_idx_d  = '0;
      dwell_cnt_d = '0;
    end

    if (en && !mode && sel_oob) begin
      err_d = 1'b1;
    end

    if (load) begin
      y_d         = chan_data;
      ch_d        = chan;
      out_valid_d = 1'b1;
      // Scan position only moves on accepted loads, so a stall never skips.
      if (mode) begin
        if (dwell_cnt_q == 8'(DWELL - 1)) begin
          dwell_cnt_d = '0;
          scan_idx_d  = (scan_idx_q == SW'(N - 1)) ? '0 : scan_idx_q + SW'(1);
        end else begin
          dwell_cnt_d = dwell_cnt_q + 8'd1;
        end
      end
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_MANUAL;
      out_valid_q <= 1'b0;
      y_q         <= '0;
      ch_q        <= '0;
      scan_idx_q  <= '0;
      dwell_cnt_q <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      y_q         <= y_d;
      ch_q        <= ch_d;
      scan_idx_q  <= scan_idx_d;
      dwell_cnt_q <= dwell_cnt_d;
      err_q       <= err_d;
    end
  end

  assign out_valid = out_valid_q;
  assign ch        = ch_q;
  assign err       = err_q;

`ifdef MUX_SCAN_TRISTATE_EN
  assign y = oe ? y_q : {W{1'bz}};
`else
  assign y = y_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mux_scan_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_mux_scan_buffer
// Description : Self-checking bench for mux_scan_buffer. Two instances share
//               the stimulus: dut0 (N=4, W=1, DWELL=2) and dut1 (N=3, W=2,
//               DWELL=1). A behavioural model tracks each instance.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mux_scan_buffer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        en = 1'b0;
  logic        mode = 1'b0;
  logic        out_ready = 1'b0;
  logic [1:0]  sel = '0;
  logic [31:0] d_all = '0;
`ifdef MUX_SCAN_TRISTATE_EN
  logic        oe = 1'b1;
`endif

  logic        v0, e0, v1, e1;
  logic [0:0]  y0;
  logic [1:0]  y1, c0, c1;

  always #5 clk = ~clk;

  mux_scan_buffer #(.N(4), .W(1), .DWELL(2)) dut0 (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .sel(sel),
    .d(d_all[3:0]), .out_ready(out_ready),
`ifdef MUX_SCAN_TRISTATE_EN
    .oe(oe),
`endif
    .out_valid(v0), .y(y0), .ch(c0), .err(e0)
  );

  mux_scan_buffer #(.N(3), .W(2), .DWELL(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .sel(sel),
    .d(d_all[5:0]), .out_ready(out_ready),
`ifdef MUX_SCAN_TRISTATE_EN
    .oe(oe),
`endif
    .out_valid(v1), .y(y1), .ch(c1), .err(e1)
  );

  // Reference model: one slot per instance.
  int NN[2] = '{4, 3};
  int WW[2] = '{1, 2};
  int DW[2] = '{2, 1};
  bit m_v[2], m_err[2], m_scan[2];
  int m_y[2], m_ch[2], m_idx[2], m_cnt[2];

  int passed = 0;
  int total  = 0;
  int fails  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_v[i] = 0; m_err[i] = 0; m_scan[i] = 0;
      m_y[i] = 0; m_ch[i] = 0; m_idx[i] = 0; m_cnt[i] = 0;
    end
  endtask

  // Applies one rising edge to the model using the current inputs.
  task automatic model_edge();
    int  chan;
    bit  enter, ld;
    for (int i = 0; i < 2; i++) begin
      enter = mode && !m_scan[i];
      if (enter) begin
        m_idx[i] = 0;
        m_cnt[i] = 0;
      end
      ld   = en && (!m_v[i] || out_ready) && !enter;
      chan = mode ? m_idx[i] : int'(sel);
      if (en && !mode && int'(sel) >= NN[i]) m_err[i] = 1;
      if (ld) begin
        m_ch[i] = chan;
        m_y[i]  = (chan < NN[i]) ? int'((d_all >> (chan * WW[i])) & ((32'd1 << WW[i]) - 1)) : 0;
        m_v[i]  = 1;
        if (mode) begin
          m_cnt[i]++;
          if (m_cnt[i] == DW[i]) begin
            m_cnt[i] = 0;
            m_idx[i] = (m_idx[i] + 1) % NN[i];
          end
        end
      end else if (m_v[i] && out_ready) begin
        m_v[i] = 0;
      end
      m_scan[i] = mode;
    end
  endtask

  task automatic check_all();
    logic [31:0] ey0, ey1;
    ey0 = m_y[0];
    ey1 = m_y[1];
`ifdef MUX_SCAN_TRISTATE_EN
    if (!oe) begin
      ey0 = {31'b0, 1'bz};
      ey1 = {30'b0, 2'bzz};
    end
`endif
    chk("valid0", 32'(v0), 32'(m_v[0]));
    chk("y0",     32'(y0), ey0);
    chk("ch0",    32'(c0), 32'(m_ch[0]));
    chk("err0",   32'(e0), 32'(m_err[0]));
    chk("valid1", 32'(v1), 32'(m_v[1]));
    chk("y1",     32'(y1), ey1);
    chk("ch1",    32'(c1), 32'(m_ch[1]));
    chk("err1",   32'(e1), 32'(m_err[1]));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  // Asserts reset between edges and checks it takes effect before the next edge.
  task automatic async_reset();
    #2 rst_n = 1'b0;
    model_reset();
    #1 check_all();
    @(negedge clk) rst_n = 1'b1;
  endtask

  int ch_seq[9] = '{0, 0, 1, 1, 2, 2, 3, 3, 0};
  int y_seq[9]  = '{1, 1, 0, 0, 1, 1, 0, 0, 1};
  logic [1:0] hold_c;
  logic [0:0] hold_y;

  initial begin
    // Power-on reset
    #1 rst_n = 1'b0;
    model_reset();
    #1 check_all();
    @(negedge clk) rst_n = 1'b1;

    // Manual walk of all {sel,d} combinations for the 4-channel instance
    en = 1'b1; mode = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < 64; c++) begin
      sel   = 2'(c >> 4);
      d_all = ($urandom() & 32'hFFFF_FFF0) | 32'(c & 15);
      step();
      chk("walk_y", 32'(y0), 32'((c & 15) >> (c >> 4)) & 32'd1);
    end

    // Mid-transfer reset with a stalled sample in the buffer
    out_ready = 1'b0;
    step();
    chk("pend_valid", 32'(v0), 32'd1);
    async_reset();
    chk("rst_valid", 32'(v0), 32'd0);

    // Auto-scan sequence
    out_ready = 1'b1; mode = 1'b1; d_all = 32'h5;
    step();
    chk("enter_novalid", 32'(v0), 32'd0);
    for (int k = 0; k < 9; k++) begin
      step();
      chk("scan_ch0", 32'(c0), 32'(ch_seq[k]));
      chk("scan_y0",  32'(y0), 32'(y_seq[k]));
      chk("scan_ch1", 32'(c1), 32'(k % 3));
    end

    // Stall at channel 2
    for (int k = 0; k < 20 && m_ch[0] != 2; k++) step();
    chk("reach_ch2", 32'(c0), 32'd2);
    hold_c = c0; hold_y = y0;
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("stall_ch", 32'(c0), 32'(hold_c));
      chk("stall_y",  32'(y0), 32'(hold_y));
      chk("stall_v",  32'(v0), 32'd1);
    end
    out_ready = 1'b1;
    step();
    chk("stall_next", 32'(c0), 32'd2);

    // Out-of-range manual select on the 3-channel instance
    chk("err_pre", 32'(e1), 32'd0);
    mode = 1'b0; sel = 2'd3; d_all = 32'hFFFF_FFFF;
    step();
    chk("oob_err", 32'(e1), 32'd1);
    chk("oob_y",   32'(y1), 32'd0);
    chk("oob_ch",  32'(c1), 32'd3);
    sel = 2'd0; en = 1'b0;
    step();
    step();
    chk("err_sticky", 32'(e1), 32'd1);

    // Randomized traffic
    for (int k = 0; k < 400; k++) begin
      en        = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      sel       = 2'($urandom_range(0, 3));
      d_all     = $urandom();
      if ($urandom_range(0, 7) == 0) mode = ~mode;
      step();
      if (k == 200) async_reset();
    end

`ifdef MUX_SCAN_TRISTATE_EN
    oe = 1'b0; en = 1'b1; out_ready = 1'b1; mode = 1'b1;
    for (int k = 0; k < 4; k++) begin
      out_ready = k[0];
      step();
    end
    oe = 1'b1;
    #1 check_all();
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
